// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package ssd_pkg;

  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_MINUS = 4'hF;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  typedef enum logic {
    BLANK,
    DRIVE
  } state_t;

endpackage

// File: rtl/ssd_scan_driver_bcd_to_seg.sv
// Combinational decoder from a 4-bit digit/sign code to active-low segments.
// Codes 0-9 give digits, 4'hF gives a minus sign, everything else is blank.
module bcd_to_seg
  import ssd_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Look up the segment pattern for the selected code.
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:       seg = SEG_0;
      4'd1:       seg = SEG_1;
      4'd2:       seg = SEG_2;
      4'd3:       seg = SEG_3;
      4'd4:       seg = SEG_4;
      4'd5:       seg = SEG_5;
      4'd6:       seg = SEG_6;
      4'd7:       seg = SEG_7;
      4'd8:       seg = SEG_8;
      4'd9:       seg = SEG_9;
      CODE_MINUS: seg = SEG_MINUS;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode seven-segment scan driver.
// A shadow register collects new display words; they are swapped into the
// display register only at the frame boundary so a frame never mixes words.
// Each digit slot starts with a short all-anodes-off gap against ghosting.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] BCDIN,
  input  logic        LOAD,
  input  logic [3:0]  DP_MASK,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  state_t           state;
  state_t           next_state;
  logic [15:0]      shadow;
  logic [15:0]      disp;
  logic             pending;
  logic [3:0]       code_sel;
  logic [6:0]       seg_dec;
  logic             slot_wrap;
  logic             frame_end;

  assign slot_wrap = (cnt == CNT_LAST);
  assign frame_end = slot_wrap && (idx == 2'd0);

  // Slot counter and digit index; the index steps 3,2,1,0 on every slot wrap.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt <= '0;
      idx <= 2'd3;
    end else if (slot_wrap) begin
      cnt <= '0;
      idx <= idx - 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Scan state register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= BLANK;
    end else begin
      state <= next_state;
    end
  end

  // Enter DRIVE as the counter reaches BLANK_CYCLES, fall back to BLANK on wrap.
  always_comb begin
    next_state = state;
    case (state)
      BLANK:   if (cnt == CNT_BLANK_END) next_state = DRIVE;
      DRIVE:   if (slot_wrap)            next_state = BLANK;
      default: next_state = BLANK;
    endcase
  end

  // Shadow capture and frame-boundary swap; a LOAD on the boundary bypasses the shadow.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      shadow  <= 16'hAAAA;
      disp    <= 16'hAAAA;
      pending <= 1'b0;
    end else begin
      if (LOAD) begin
        shadow <= BCDIN;
      end
      if (frame_end) begin
        pending <= 1'b0;
        if (LOAD) begin
          disp <= BCDIN;
        end else if (pending) begin
          disp <= shadow;
        end
      end else if (LOAD) begin
        pending <= 1'b1;
      end
    end
  end

  // Pick the code for the digit being scanned, optionally blanking leading zeros.
  always_comb begin
    code_sel = CODE_BLANK;
    case (idx)
      2'd3: code_sel = disp[15:12];
      2'd2: code_sel = disp[11:8];
      2'd1: code_sel = disp[7:4];
      2'd0: code_sel = disp[3:0];
      default: code_sel = CODE_BLANK;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 2'd2 && disp[11:8] == 4'd0) begin
      code_sel = CODE_BLANK;
    end
    if (idx == 2'd1 && disp[11:4] == 8'd0) begin
      code_sel = CODE_BLANK;
    end
`endif
  end

  bcd_to_seg u_dec (
    .code (code_sel),
    .seg  (seg_dec)
  );

  // Registered display outputs, one cycle behind state/counter/index.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      AN  <= 4'b1111;
      SEG <= SEG_BLANK;
      DP  <= 1'b1;
    end else if (state == DRIVE) begin
      AN  <= ~(4'b0001 << idx);
      SEG <= seg_dec;
      DP  <= ~DP_MASK[idx];
    end else begin
      AN  <= 4'b1111;
      SEG <= SEG_BLANK;
      DP  <= 1'b1;
    end
  end

endmodule
